fifo_rst_sequencer: RTL
=======================

// Module: fifo_rst_sequencer
// PURPOSE
//  Upstream of the FIFO reset FSM. Qualifies MMCM lock, then drives that FSM's reset input (SEQ_RST).
//  Watches the FSM's DONE level (FIFO_DONE) and raises READY for the readout path.
//  Handles lock loss, soft-reset requests and downstream timeout (FAULT).
// PARAMETERS
//  LOCK_STABLE_CYC   256  consecutive synced-LOCKED cycles required before reset release sequence
//  RST_HOLD_CYC      16   cycles SEQ_RST held high in HOLD_RST (min 2)
//  DONE_TIMEOUT_CYC  64   max cycles in WAIT_DONE for FIFO_DONE (downstream needs ~30)
//  MAX_RETRY         3    timeout retries before FAULT (used only with FIFO_RST_SEQ_RETRY_EN)
// PORTS
//  CLK           in   1  system clock
//  RST           in   1  asynchronous, active-high reset
//  LOCKED        in   1  MMCM lock, asynchronous to CLK
//  SOFT_RST_REQ  in   1  synchronous 1-cycle request to re-run the FIFO reset
//  FIFO_DONE     in   1  DONE level from downstream FIFO reset FSM
//  SEQ_RST       out  1  reset to downstream FIFO reset FSM, active-high
//  READY         out  1  FIFOs reset and released; readout may start
//  FAULT         out  1  sticky: FIFO_DONE timed out
//  STATE_OUT     out  3  current state encoding, for status registers
// BEHAVIOUR
//  - Reset values: SEQ_RST=1, READY=0, FAULT=0, STATE_OUT=WAIT_LOCK, all counters 0. All outputs registered.
//  - LOCKED passes a 2-flop synchronizer -> locked_s (2-cycle latency).
//  - Encoding: WAIT_LOCK=0, HOLD_RST=1, WAIT_DONE=2, RUN=3, FLT=4. Other codes -> WAIT_LOCK.
//  - WAIT_LOCK: SEQ_RST=1. stab_cnt increments while locked_s=1 and clears when locked_s=0.
//    When stab_cnt==LOCK_STABLE_CYC-1 and locked_s=1 -> HOLD_RST.
//  - HOLD_RST: SEQ_RST=1 for exactly RST_HOLD_CYC cycles, then -> WAIT_DONE.
//  - WAIT_DONE: SEQ_RST=0. tmo_cnt counts up from 0.
//    FIFO_DONE=1 -> RUN.
//    tmo_cnt==DONE_TIMEOUT_CYC-1 without FIFO_DONE -> timeout handling (see CONFIGURATION).
//  - RUN: READY=1 while state==RUN. FIFO_DONE dropping in RUN -> FLT (FAULT=1).
//  - FLT: SEQ_RST=0, READY=0, FAULT=1. FAULT stays 1 until RST or until a SOFT_RST_REQ is accepted.
//  - Priority each cycle: locked_s=0 outside WAIT_LOCK > SOFT_RST_REQ > normal transition.
//    - locked_s=0: -> WAIT_LOCK next cycle. SEQ_RST=1 and READY=0 in that same next cycle. Counters cleared.
//    - SOFT_RST_REQ: accepted in WAIT_DONE, RUN or FLT. -> HOLD_RST, FAULT cleared, retry count cleared.
//      Ignored in WAIT_LOCK and HOLD_RST.
//  - FIFO_DONE is ignored outside WAIT_DONE and RUN. FIFO_DONE=1 on the first WAIT_DONE cycle -> RUN.
//  - Counter widths: $clog2(max(LOCK_STABLE_CYC,RST_HOLD_CYC,DONE_TIMEOUT_CYC)+1). No wrap; counters clear on state entry.
//  - RST asserted mid-sequence: immediate return to reset values, regardless of state.
// CONFIGURATION
//  FIFO_RST_SEQ_RETRY_EN defined:
//    - On timeout with retry_cnt<MAX_RETRY: retry_cnt++ and -> HOLD_RST (FAULT stays 0).
//    - On timeout with retry_cnt==MAX_RETRY: -> FLT.
//    - retry_cnt clears on entry to RUN or WAIT_LOCK.
//  FIFO_RST_SEQ_RETRY_EN undefined: timeout -> FLT directly. No retry counter is built. MAX_RETRY is unused.
// STRUCTURE
//  - Shared package/include fifo_rst_pkg: state encodings (3-bit localparams) and STATE_OUT decode for status/sim names.
//  - Sub-module sync_2ff (1-bit, 2-flop synchronizer with async reset to 0) for LOCKED.
//  - Remaining logic lives in one FSM + datapath always block pair.
// TESTING
//  Small params for all tests: LOCK_STABLE_CYC=8, RST_HOLD_CYC=4, DONE_TIMEOUT_CYC=16, MAX_RETRY=2.
//  1. Normal bring-up.
//     Stimulus: LOCKED=1 at cycle 0; model raises FIFO_DONE 5 cycles after SEQ_RST falls.
//     Required: SEQ_RST=1 through cycle 13, falls at cycle 14; READY=1 at cycle 20; FAULT=0.
//  2. Lock glitch.
//     Stimulus: LOCKED low 1 cycle at cycle 5.
//     Required: stab_cnt restarts; SEQ_RST fall delayed by 6 cycles vs test 1.
//  3. Lock loss in RUN.
//     Stimulus: drop LOCKED while READY=1.
//     Required: READY=0 and SEQ_RST=1 exactly 3 cycles after the LOCKED edge (2 sync + 1); full re-sequence once LOCKED returns.
//  4. Soft reset.
//     Stimulus: 1-cycle SOFT_RST_REQ in RUN.
//     Required: SEQ_RST=1 for 4 cycles, READY=0 until FIFO_DONE returns; SOFT_RST_REQ during HOLD_RST ignored.
//  5. Timeout.
//     Stimulus: FIFO_DONE tied 0.
//     Required, macro off: FAULT=1 16 cycles after SEQ_RST falls.
//     Required, macro on: 3 HOLD_RST pulses, then FAULT=1.
//     Then SOFT_RST_REQ: FAULT clears.
//  6. RST mid-WAIT_DONE.
//     Required: next edge shows SEQ_RST=1, READY=0, FAULT=0, STATE_OUT=0.

Source files
------------

// File: rtl/fifo_rst_pkg.sv
// Shared definitions for the FIFO reset sequencer: state encodings, STATE_OUT decode
// and a constant helper used for counter sizing.
package fifo_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD_RST  = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FLT       = 3'd4
  } state_t;

  // Any unused code is treated as WAIT_LOCK so a corrupted state register self-recovers.
  function automatic state_t state_decode(input logic [2:0] code);
    case (code)
      3'd1:    return ST_HOLD_RST;
      3'd2:    return ST_WAIT_DONE;
      3'd3:    return ST_RUN;
      3'd4:    return ST_FLT;
      default: return ST_WAIT_LOCK;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset to 0.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fifo_rst_sequencer.sv
// Qualifies MMCM lock, sequences the downstream FIFO reset FSM and reports READY/FAULT.
// Optional timeout retries are built when FIFO_RST_SEQ_RETRY_EN is defined.
module fifo_rst_sequencer
  import fifo_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int RST_HOLD_CYC     = 16,
  parameter int DONE_TIMEOUT_CYC = 64,
  parameter int MAX_RETRY        = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOCKED,
  input  logic       SOFT_RST_REQ,
  input  logic       FIFO_DONE,
  output logic       SEQ_RST,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE_OUT
);

  localparam int CNT_W = $clog2(max3(LOCK_STABLE_CYC, RST_HOLD_CYC, DONE_TIMEOUT_CYC) + 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DONE_TIMEOUT_CYC - 1);

  if (RST_HOLD_CYC < 2 || LOCK_STABLE_CYC < 1 || DONE_TIMEOUT_CYC < 1 || MAX_RETRY < 0) begin : g_param_check
    $error("fifo_rst_sequencer: illegal parameter value");
  end

  logic             w_locked_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             r_seq_rst;
  logic             r_ready;
  state_t           w_state_cur;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fault_nxt;
  logic             w_seq_rst_nxt;
  logic             w_ready_nxt;

`ifdef FIFO_RST_SEQ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  logic [RETRY_W-1:0] r_retry_cnt;
  logic [RETRY_W-1:0] w_retry_nxt;
`endif

  sync_2ff u_lock_sync (
    .CLK (CLK),
    .RST (RST),
    .i_d (LOCKED),
    .o_q (w_locked_s)
  );

  assign w_state_cur = state_decode(r_state);

  // One shared counter: stability count, hold count or timeout count depending on state.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = w_state_cur;
    w_cnt_nxt   = r_cnt;
    w_fault_nxt = r_fault;
`ifdef FIFO_RST_SEQ_RETRY_EN
    w_retry_nxt = r_retry_cnt;
`endif

    if (w_state_cur != ST_WAIT_LOCK && !w_locked_s) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
`ifdef FIFO_RST_SEQ_RETRY_EN
      w_retry_nxt = '0;
`endif
    end else if (SOFT_RST_REQ &&
                 (w_state_cur inside {ST_WAIT_DONE, ST_RUN, ST_FLT})) begin
      w_state_nxt = ST_HOLD_RST;
      w_cnt_nxt   = '0;
      w_fault_nxt = 1'b0;
`ifdef FIFO_RST_SEQ_RETRY_EN
      w_retry_nxt = '0;
`endif
    end else begin
      case (w_state_cur)
        ST_WAIT_LOCK: begin
          if (!w_locked_s) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == STAB_LAST) begin
            w_state_nxt = ST_HOLD_RST;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD_RST: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_WAIT_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (FIFO_DONE) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
`ifdef FIFO_RST_SEQ_RETRY_EN
            w_retry_nxt = '0;
`endif
          end else if (r_cnt == TMO_LAST) begin
            w_cnt_nxt = '0;
`ifdef FIFO_RST_SEQ_RETRY_EN
            if (r_retry_cnt < RETRY_MAX) begin
              w_retry_nxt = r_retry_cnt + RETRY_W'(1);
              w_state_nxt = ST_HOLD_RST;
            end else begin
              w_state_nxt = ST_FLT;
              w_fault_nxt = 1'b1;
            end
`else
            w_state_nxt = ST_FLT;
            w_fault_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!FIFO_DONE) begin
            w_state_nxt = ST_FLT;
            w_fault_nxt = 1'b1;
          end
        end
        ST_FLT: begin
          w_fault_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they change in the same cycle as STATE_OUT.
    w_seq_rst_nxt = (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_HOLD_RST);
    w_ready_nxt   = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_seq_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_fault   <= w_fault_nxt;
      r_seq_rst <= w_seq_rst_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

`ifdef FIFO_RST_SEQ_RETRY_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_retry_cnt <= '0;
    end else begin
      r_retry_cnt <= w_retry_nxt;
    end
  end
`endif

  assign SEQ_RST   = r_seq_rst;
  assign READY     = r_ready;
  assign FAULT     = r_fault;
  assign STATE_OUT = r_state;

endmodule
